// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline hazard and stall controller for the 5-stage RISC-V core.
// It drives the flush / nwen (active-low write enable) inputs of the PC and
// of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves:
//   - load-use hazards
//   - taken-branch redirects
//   - instruction and data memory wait states
//   - debug halt / drain / resume
// It also counts stall cycles for performance monitoring.
//
// Ports:
//   clk_i, nrst_i                 core clock, asynchronous active-low reset
//   id_rs1_i, id_rs2_i            source registers of the ID instruction
//   id_uses_rs1_i, id_uses_rs2_i  ID instruction actually reads rs1 / rs2
//   ex_rd_i, ex_is_load_i         destination / load flag of the EX instruction
//   ex_branch_taken_i             EX instruction redirects the PC
//   imem_ready_i                  instruction memory has valid data
//   mem_req_i, dmem_ready_i       MEM-stage access request / completion
//   halt_req_i, resume_i          debug halt and resume pulses
//   stat_clear_i                  synchronous clear of stall_cycles_o
//   pc_nwen_o, pc_sel_target_o    PC hold and branch-target select
//   *_nwen_o, *_flush_o           pipeline register controls
//   halted_o                      core is halted for debug
//   stall_cycles_o                saturating count of RUN cycles with PC held
module hazard_ctrl #(
  parameter int CNT_WIDTH    = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                 clk_i,
  input  logic                 nrst_i,
  input  logic [4:0]           id_rs1_i,
  input  logic [4:0]           id_rs2_i,
  input  logic                 id_uses_rs1_i,
  input  logic                 id_uses_rs2_i,
  input  logic [4:0]           ex_rd_i,
  input  logic                 ex_is_load_i,
  input  logic                 ex_branch_taken_i,
  input  logic                 imem_ready_i,
  input  logic                 mem_req_i,
  input  logic                 dmem_ready_i,
  input  logic                 halt_req_i,
  input  logic                 resume_i,
  input  logic                 stat_clear_i,
  output logic                 pc_nwen_o,
  output logic                 pc_sel_target_o,
  output logic                 if_id_nwen_o,
  output logic                 if_id_flush_o,
  output logic                 id_ex_nwen_o,
  output logic                 id_ex_flush_o,
  output logic                 ex_mem_nwen_o,
  output logic                 ex_mem_flush_o,
  output logic                 mem_wb_nwen_o,
  output logic                 mem_wb_flush_o,
  output logic                 halted_o,
  output logic [CNT_WIDTH-1:0] stall_cycles_o
);

  localparam int DCW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e               state_q;
  logic [DCW-1:0]       drain_cnt_q;
  logic                 halt_pend_q;
  logic                 halted_q;
  logic [CNT_WIDTH-1:0] stall_q;

  logic dmem_busy;
  logic redirect;
  logic rs_match;
  logic load_use;
  logic ifetch_wait;
  logic freeze_front;

  // Hazard classification; the priority chain keeps the four conditions
  // mutually exclusive.
  always_comb begin
    dmem_busy   = mem_req_i & ~dmem_ready_i;
    redirect    = ex_branch_taken_i & ~dmem_busy;
    rs_match    = (id_uses_rs1_i & (id_rs1_i == ex_rd_i)) |
                  (id_uses_rs2_i & (id_rs2_i == ex_rd_i));
    load_use    = ex_is_load_i & (ex_rd_i != 5'd0) & rs_match &
                  ~dmem_busy & ~redirect;
    ifetch_wait = ~imem_ready_i & ~dmem_busy & ~redirect & ~load_use;
    // While draining, a redirect still lets the PC load its target so that
    // resume fetches from the correct address.
    freeze_front = ((state_q == DRAIN) & ~redirect) | (state_q == HALTED);
  end

  // Control outputs. Reset forces every register to clear (flush wins over
  // nwen inside the pipeline registers); a data-memory wait freezes the
  // whole pipeline and overrides every other action, FSM included.
  always_comb begin
    pc_nwen_o       = 1'b0;
    pc_sel_target_o = 1'b0;
    if_id_nwen_o    = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_nwen_o    = 1'b0;
    id_ex_flush_o   = 1'b0;
    ex_mem_nwen_o   = 1'b0;
    ex_mem_flush_o  = 1'b0;
    mem_wb_nwen_o   = 1'b0;
    mem_wb_flush_o  = 1'b0;
    if (!nrst_i) begin
      pc_nwen_o      = 1'b1;
      if_id_nwen_o   = 1'b1;
      if_id_flush_o  = 1'b1;
      id_ex_nwen_o   = 1'b1;
      id_ex_flush_o  = 1'b1;
      ex_mem_nwen_o  = 1'b1;
      ex_mem_flush_o = 1'b1;
      mem_wb_nwen_o  = 1'b1;
      mem_wb_flush_o = 1'b1;
    end else if (dmem_busy) begin
      pc_nwen_o      = 1'b1;
      if_id_nwen_o   = 1'b1;
      id_ex_nwen_o   = 1'b1;
      ex_mem_nwen_o  = 1'b1;
      mem_wb_flush_o = 1'b1;
    end else begin
      if (redirect) begin
        pc_sel_target_o = 1'b1;
        if_id_flush_o   = 1'b1;
        id_ex_flush_o   = 1'b1;
      end
      if (load_use) begin
        pc_nwen_o     = 1'b1;
        if_id_nwen_o  = 1'b1;
        id_ex_flush_o = 1'b1;
      end
      if (ifetch_wait) begin
        pc_nwen_o     = 1'b1;
        if_id_flush_o = 1'b1;
      end
      if (freeze_front) begin
        pc_nwen_o     = 1'b1;
        if_id_flush_o = 1'b1;
      end
    end
  end

  // Debug FSM and stall counter. A halt request that arrives during a data
  // memory wait is remembered and taken on the first non-busy cycle.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q     <= RUN;
      drain_cnt_q <= '0;
      halt_pend_q <= 1'b0;
      halted_q    <= 1'b0;
      stall_q     <= '0;
    end else begin
      if (stat_clear_i) begin
        stall_q <= '0;
      end else if ((state_q == RUN) && pc_nwen_o && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_WIDTH'(1);
      end

      case (state_q)
        RUN: begin
          if ((halt_req_i | halt_pend_q) && !dmem_busy) begin
            state_q     <= DRAIN;
            drain_cnt_q <= '0;
            halt_pend_q <= 1'b0;
          end else if (halt_req_i) begin
            halt_pend_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (!dmem_busy) begin
            drain_cnt_q <= drain_cnt_q + DCW'(1);
            if ((drain_cnt_q + DCW'(1)) == DRAIN_LAST) begin
              state_q  <= HALTED;
              halted_q <= 1'b1;
            end
          end
        end
        HALTED: begin
          if (resume_i) begin
            state_q     <= RUN;
            halted_q    <= 1'b0;
            drain_cnt_q <= '0;
          end
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign halted_o       = halted_q;
  assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios followed by randomized
// stimulus, all checked against a behavioural model of the controller.
module tb_hazard_ctrl;

  localparam int CW       = 4;
  localparam int DC       = 4;
  localparam int STALLMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          nrst;
  logic [4:0]    idRs1, idRs2, exRd;
  logic          idUsesRs1, idUsesRs2, exIsLoad, exBranchTaken;
  logic          imemReady, memReq, dmemReady, haltReq, resume, statClear;
  logic          pcNwen, pcSelTarget, ifIdNwen, ifIdFlush, idExNwen, idExFlush;
  logic          exMemNwen, exMemFlush, memWbNwen, memWbFlush, halted;
  logic [CW-1:0] stallCycles;

  int vectorCount = 0;
  int missCount   = 0;

  typedef enum {M_RUN, M_DRAIN, M_HALT} modeT;
  modeT mode;
  int   drainSeen;
  bit   haltPending;
  int   stallCount;

  hazard_ctrl #(.CNT_WIDTH(CW), .DRAIN_CYCLES(DC)) dut (
    .clk_i(clk), .nrst_i(nrst),
    .id_rs1_i(idRs1), .id_rs2_i(idRs2),
    .id_uses_rs1_i(idUsesRs1), .id_uses_rs2_i(idUsesRs2),
    .ex_rd_i(exRd), .ex_is_load_i(exIsLoad), .ex_branch_taken_i(exBranchTaken),
    .imem_ready_i(imemReady), .mem_req_i(memReq), .dmem_ready_i(dmemReady),
    .halt_req_i(haltReq), .resume_i(resume), .stat_clear_i(statClear),
    .pc_nwen_o(pcNwen), .pc_sel_target_o(pcSelTarget),
    .if_id_nwen_o(ifIdNwen), .if_id_flush_o(ifIdFlush),
    .id_ex_nwen_o(idExNwen), .id_ex_flush_o(idExFlush),
    .ex_mem_nwen_o(exMemNwen), .ex_mem_flush_o(exMemFlush),
    .mem_wb_nwen_o(memWbNwen), .mem_wb_flush_o(memWbFlush),
    .halted_o(halted), .stall_cycles_o(stallCycles)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [10:0] observedCtrl();
    return {pcNwen, pcSelTarget, ifIdNwen, ifIdFlush, idExNwen, idExFlush,
            exMemNwen, exMemFlush, memWbNwen, memWbFlush, halted};
  endfunction

  // Model of the control outputs derived from the hazard rules.
  function automatic logic [10:0] expectedCtrl();
    logic busy, redir, hit, lu, fw;
    logic pcHold, pcSel, ifHold, ifFlush, idHold, idFlush;
    logic exHold, exFlush, wbHold, wbFlush, isHalted;
    busy  = memReq && !dmemReady;
    redir = exBranchTaken && !busy;
    hit   = exIsLoad && (exRd != 0) &&
            ((idUsesRs1 && idRs1 == exRd) || (idUsesRs2 && idRs2 == exRd));
    lu    = hit && !busy && !redir;
    fw    = !imemReady && !busy && !redir && !lu;
    {pcHold, pcSel, ifHold, ifFlush, idHold, idFlush} = '0;
    {exHold, exFlush, wbHold, wbFlush} = '0;
    isHalted = (mode == M_HALT);
    if (!nrst) begin
      {pcHold, ifHold, ifFlush, idHold, idFlush} = '1;
      {exHold, exFlush, wbHold, wbFlush} = '1;
    end else if (busy) begin
      pcHold = 1; ifHold = 1; idHold = 1; exHold = 1; wbFlush = 1;
    end else begin
      pcSel   = redir;
      pcHold  = lu || fw;
      ifHold  = lu;
      ifFlush = redir || fw;
      idFlush = redir || lu;
      if ((mode == M_DRAIN && !redir) || mode == M_HALT) begin
        pcHold  = 1;
        ifFlush = 1;
      end
    end
    return {pcHold, pcSel, ifHold, ifFlush, idHold, idFlush,
            exHold, exFlush, wbHold, wbFlush, isHalted};
  endfunction

  task automatic modelReset();
    mode        = M_RUN;
    drainSeen   = 0;
    haltPending = 0;
    stallCount  = 0;
  endtask

  task automatic modelEdge();
    logic [10:0] ctrl;
    logic        busy;
    ctrl = expectedCtrl();
    busy = memReq && !dmemReady;
    if (statClear) stallCount = 0;
    else if (mode == M_RUN && ctrl[10] && stallCount < STALLMAX) stallCount++;
    case (mode)
      M_RUN: begin
        if ((haltReq || haltPending) && !busy) begin
          mode = M_DRAIN; drainSeen = 0; haltPending = 0;
        end else if (haltReq) begin
          haltPending = 1;
        end
      end
      M_DRAIN: begin
        if (!busy) begin
          drainSeen++;
          if (drainSeen == DC) mode = M_HALT;
        end
      end
      default: if (resume) mode = M_RUN;
    endcase
  endtask

  // One clock cycle: check the combinational controls, clock the edge, then
  // check the registered state.
  task automatic applyStimulus(input string tag);
    #1;
    checkOutput({tag, ".ctrl"}, 32'(observedCtrl()), 32'(expectedCtrl()));
    @(posedge clk);
    if (!nrst) modelReset();
    else modelEdge();
    #1;
    checkOutput({tag, ".stall"}, 32'(stallCycles), stallCount);
    checkOutput({tag, ".halted"}, 32'(halted), 32'(mode == M_HALT));
  endtask

  task automatic setIdle();
    idRs1 = 0; idRs2 = 0; exRd = 0;
    idUsesRs1 = 0; idUsesRs2 = 0; exIsLoad = 0; exBranchTaken = 0;
    imemReady = 1; memReq = 0; dmemReady = 1;
    haltReq = 0; resume = 0; statClear = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    setIdle();
    nrst = 1'b0;
    modelReset();
    applyStimulus("reset");
    applyStimulus("reset");
    nrst = 1'b1;
    applyStimulus("idle");

    // Load-use stall and its ex_rd == 0 counterpart.
    statClear = 1; applyStimulus("clear"); statClear = 0;
    exIsLoad = 1; exRd = 5; idRs1 = 5; idUsesRs1 = 1;
    applyStimulus("loadUse");
    checkOutput("loadUseCount", 32'(stallCycles), 1);
    exRd = 0; idRs1 = 0;
    applyStimulus("loadUseX0");
    checkOutput("loadUseX0Count", 32'(stallCycles), 1);

    // Branch during a 3-cycle data-memory wait.
    setIdle();
    exBranchTaken = 1; memReq = 1; dmemReady = 0;
    repeat (3) applyStimulus("branchWait");
    dmemReady = 1;
    applyStimulus("branchGo");

    // Branch and load-use together: redirect only.
    setIdle();
    exBranchTaken = 1; exIsLoad = 1; exRd = 7; idRs2 = 7; idUsesRs2 = 1;
    #1;
    checkOutput("branchLoadPc", 32'(pcNwen), 0);
    checkOutput("branchLoadIdEx", 32'(idExFlush), 1);
    applyStimulus("branchLoad");

    // Halt / drain with no interference.
    setIdle();
    haltReq = 1; applyStimulus("haltPulse"); haltReq = 0;
    n = 0;
    while (!halted && n < 20) begin applyStimulus("drain"); n++; end
    checkOutput("haltLatency", n, DC);
    resume = 1; applyStimulus("resume"); resume = 0;
    #1;
    checkOutput("resumePc", 32'(pcNwen), 0);
    checkOutput("resumeHalted", 32'(halted), 0);

    // Halt / drain with two busy cycles inside the drain.
    haltReq = 1; applyStimulus("haltPulse2"); haltReq = 0;
    n = 0;
    while (!halted && n < 30) begin
      if (n == 1 || n == 2) begin memReq = 1; dmemReady = 0; end
      else begin memReq = 0; dmemReady = 1; end
      applyStimulus("drainBusy");
      n++;
    end
    memReq = 0; dmemReady = 1;
    checkOutput("haltLatencyBusy", n, DC + 2);

    // Asynchronous reset while halted.
    nrst = 1'b0;
    modelReset();
    #1;
    checkOutput("asyncReset", 32'(observedCtrl()), 32'(11'b10111111110));
    applyStimulus("inReset");
    nrst = 1'b1;
    applyStimulus("afterReset");
    checkOutput("afterResetStall", 32'(stallCycles), 0);

    // Saturation and clear.
    imemReady = 0;
    repeat (20) applyStimulus("ifetchWait");
    checkOutput("saturate", 32'(stallCycles), STALLMAX);
    statClear = 1; applyStimulus("satClear"); statClear = 0;
    checkOutput("satCleared", 32'(stallCycles), 0);
    setIdle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      idRs1         = 5'($urandom_range(0, 3));
      idRs2         = 5'($urandom_range(0, 3));
      exRd          = 5'($urandom_range(0, 3));
      idUsesRs1     = 1'($urandom_range(0, 1));
      idUsesRs2     = 1'($urandom_range(0, 1));
      exIsLoad      = ($urandom_range(0, 2) == 0);
      exBranchTaken = ($urandom_range(0, 5) == 0);
      imemReady     = ($urandom_range(0, 3) != 0);
      memReq        = ($urandom_range(0, 2) == 0);
      dmemReady     = 1'($urandom_range(0, 1));
      haltReq       = ($urandom_range(0, 9) == 0);
      resume        = ($urandom_range(0, 5) == 0);
      statClear     = ($urandom_range(0, 15) == 0);
      applyStimulus("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
